// File: rtl/excep_arbiter.sv
// Exception/interrupt sequencer between MEM and cp0: synchronizes interrupt lines,
// picks the highest-priority event, commits it to cp0 for one cycle, then flushes.
module excep_arbiter #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [31:0] pc_i,
  input  logic        in_delayslot_i,
  input  logic [31:0] excep_type_i,
  input  logic [31:0] mem_addr_i,
  input  logic [5:0]  int_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  hw_ip_o,
  output logic        excep_valid_o,
  output logic [4:0]  excep_code_o,
  output logic        epc_we_o,
  output logic [31:0] excep_epc_o,
  output logic        excep_bd_o,
  output logic        badvaddr_we_o,
  output logic [31:0] badvaddr_o,
  output logic        eret_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        stall_o
);

  typedef enum logic [1:0] {IDLE, FLUSH, RECOVER} state_e;

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [5:0]  sync1_q, sync2_q;
  logic        excep_valid_q, excep_valid_d;
  logic [4:0]  code_q, code_d;
  logic        epc_we_q, epc_we_d;
  logic [31:0] epc_q, epc_d;
  logic        bd_q, bd_d;
  logic        bav_we_q, bav_we_d;
  logic [31:0] bav_q, bav_d;
  logic        eret_q, eret_d;
  logic [31:0] new_pc_q, new_pc_d;

  logic        int_pend;
  logic        ev;
  logic        ev_eret;
  logic [4:0]  ev_code;
  logic        ev_bav_we;
  logic [31:0] ev_bav;
  logic        take;

  logic unused_bits;
  assign unused_bits = ^{excep_type_i[24:1], cp0_status_i[31:16], cp0_status_i[7:2],
                         cp0_cause_i[31:10], cp0_cause_i[7:0]};

  assign int_pend = (((sync2_q & cp0_status_i[15:10]) != 6'd0) ||
                     ((cp0_cause_i[9:8] & cp0_status_i[9:8]) != 2'd0)) &&
                    cp0_status_i[0] && !cp0_status_i[1];

  // Priority encoder: interrupt first, ERET last.
  // NOTE: every variable written in an always_comb gets a default first so no latch is inferred.
  always_comb begin
    ev        = 1'b1;
    ev_eret   = 1'b0;
    ev_code   = 5'h00;
    ev_bav_we = 1'b0;
    ev_bav    = 32'd0;
    if (int_pend) begin
      ev_code = 5'h00;
    end else if (excep_type_i[31]) begin
      ev_code   = 5'h04;
      ev_bav_we = 1'b1;
      ev_bav    = pc_i;
    end else if (excep_type_i[30]) begin
      ev_code = 5'h0A;
    end else if (excep_type_i[29]) begin
      ev_code = 5'h0C;
    end else if (excep_type_i[28]) begin
      ev_code = 5'h09;
    end else if (excep_type_i[27]) begin
      ev_code = 5'h08;
    end else if (excep_type_i[26]) begin
      ev_code   = 5'h04;
      ev_bav_we = 1'b1;
      ev_bav    = mem_addr_i;
    end else if (excep_type_i[25]) begin
      ev_code   = 5'h05;
      ev_bav_we = 1'b1;
      ev_bav    = mem_addr_i;
    end else if (excep_type_i[0]) begin
      ev_eret = 1'b1;
    end else begin
      ev = 1'b0;
    end
  end

  assign take = (state_q == IDLE) && valid_i && ev;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    new_pc_d      = new_pc_q;
    excep_valid_d = 1'b0;
    code_d        = 5'h00;
    epc_we_d      = 1'b0;
    epc_d         = 32'd0;
    bd_d          = 1'b0;
    bav_we_d      = 1'b0;
    bav_d         = 32'd0;
    eret_d        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (take) begin
          state_d = FLUSH;
          cnt_d   = FLUSH_INIT;
          if (ev_eret) begin
            eret_d   = 1'b1;
            new_pc_d = cp0_epc_i;
          end else begin
            excep_valid_d = 1'b1;
            code_d        = ev_code;
            epc_we_d      = !cp0_status_i[1];
            epc_d         = in_delayslot_i ? (pc_i - 32'd4) : pc_i;
            bd_d          = in_delayslot_i;
            bav_we_d      = ev_bav_we;
            bav_d         = ev_bav;
            new_pc_d      = EXC_VECTOR;
          end
        end
      end
      FLUSH: begin
        if (cnt_q <= 4'd1) begin
          state_d = RECOVER;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; blocking here would race other flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      sync1_q       <= 6'd0;
      sync2_q       <= 6'd0;
      excep_valid_q <= 1'b0;
      code_q        <= 5'h00;
      epc_we_q      <= 1'b0;
      epc_q         <= 32'd0;
      bd_q          <= 1'b0;
      bav_we_q      <= 1'b0;
      bav_q         <= 32'd0;
      eret_q        <= 1'b0;
      new_pc_q      <= 32'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sync1_q       <= int_i;
      sync2_q       <= sync1_q;
      excep_valid_q <= excep_valid_d;
      code_q        <= code_d;
      epc_we_q      <= epc_we_d;
      epc_q         <= epc_d;
      bd_q          <= bd_d;
      bav_we_q      <= bav_we_d;
      bav_q         <= bav_d;
      eret_q        <= eret_d;
      new_pc_q      <= new_pc_d;
    end
  end

  assign hw_ip_o       = sync2_q;
  assign excep_valid_o = excep_valid_q;
  assign excep_code_o  = code_q;
  assign epc_we_o      = epc_we_q;
  assign excep_epc_o   = epc_q;
  assign excep_bd_o    = bd_q;
  assign badvaddr_we_o = bav_we_q;
  assign badvaddr_o    = bav_q;
  assign eret_o        = eret_q;
  // Decoded straight from the state so an asynchronous reset drops them at once.
  assign flush_o       = (state_q == FLUSH);
  assign stall_o       = (state_q == FLUSH);
  assign new_pc_o      = new_pc_q;

endmodule

// File: tb/tb_excep_arbiter.sv
// Randomized scoreboard bench for excep_arbiter: a priority-list reference model
// queues expected commits; a negedge monitor pops and compares them.
module tb_excep_arbiter;

  localparam int          F   = 2;
  localparam logic [31:0] VEC = 32'hBFC0_0380;
  localparam int          N   = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic [31:0] pc_i = '0;
  logic        in_delayslot_i = 1'b0;
  logic [31:0] excep_type_i = '0;
  logic [31:0] mem_addr_i = '0;
  logic [5:0]  int_i = '0;
  logic [31:0] cp0_status_i = '0;
  logic [31:0] cp0_cause_i = '0;
  logic [31:0] cp0_epc_i = '0;
  logic [5:0]  hw_ip_o;
  logic        excep_valid_o;
  logic [4:0]  excep_code_o;
  logic        epc_we_o;
  logic [31:0] excep_epc_o;
  logic        excep_bd_o;
  logic        badvaddr_we_o;
  logic [31:0] badvaddr_o;
  logic        eret_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        stall_o;

  excep_arbiter #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(F)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .pc_i(pc_i),
    .in_delayslot_i(in_delayslot_i), .excep_type_i(excep_type_i),
    .mem_addr_i(mem_addr_i), .int_i(int_i), .cp0_status_i(cp0_status_i),
    .cp0_cause_i(cp0_cause_i), .cp0_epc_i(cp0_epc_i), .hw_ip_o(hw_ip_o),
    .excep_valid_o(excep_valid_o), .excep_code_o(excep_code_o),
    .epc_we_o(epc_we_o), .excep_epc_o(excep_epc_o), .excep_bd_o(excep_bd_o),
    .badvaddr_we_o(badvaddr_we_o), .badvaddr_o(badvaddr_o), .eret_o(eret_o),
    .flush_o(flush_o), .new_pc_o(new_pc_o), .stall_o(stall_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          eret;
    logic [4:0]  code;
    logic [31:0] epc;
    bit          bd;
    bit          epc_we;
    bit          bav_we;
    logic [31:0] bav;
    logic [31:0] newpc;
  } rec_t;

  rec_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          e        = 0;
  int          next_ok  = 0;
  logic [5:0]  ints[N];
  bit          exp_flush[N];
  logic [31:0] exp_newpc[N];

  int          pri_bit[7]  = '{31, 30, 29, 28, 27, 26, 25};
  logic [4:0]  pri_code[7] = '{5'h04, 5'h0A, 5'h0C, 5'h09, 5'h08, 5'h04, 5'h05};
  logic [31:0] st_pool[6]  = '{32'h0000_FF01, 32'h0000_0401, 32'h0000_0403,
                               32'h0000_FF00, 32'h0000_0301, 32'h0000_FC03};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, e);
    end
  endtask

  // Reference: pending interrupt beats the flag list (in priority order), ERET comes last.
  function automatic bit model(input logic [31:0] pc, input bit ds, input logic [31:0] et,
                               input logic [31:0] addr, input logic [5:0] hw,
                               input logic [31:0] st, input logic [31:0] ca,
                               input logic [31:0] epc_in, output rec_t r);
    bit pend;
    r.eret   = 0;
    r.code   = 5'h00;
    r.epc    = ds ? pc - 32'd4 : pc;
    r.bd     = ds;
    r.epc_we = !st[1];
    r.bav_we = 0;
    r.bav    = 32'd0;
    r.newpc  = VEC;
    pend = ((hw & st[15:10]) != 0 || (ca[9:8] & st[9:8]) != 0) && st[0] && !st[1];
    if (pend) return 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (et[pri_bit[k]]) begin
        r.code = pri_code[k];
        if (k == 0) begin
          r.bav_we = 1;
          r.bav    = pc;
        end else if (k >= 5) begin
          r.bav_we = 1;
          r.bav    = addr;
        end
        return 1'b1;
      end
    end
    if (et[0]) begin
      r.eret  = 1;
      r.newpc = epc_in;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  // Apply one cycle of inputs, predict the coming edge, then advance past it.
  task automatic cyc(input bit v, input logic [31:0] pc, input bit ds, input logic [31:0] et,
                     input logic [31:0] addr, input logic [5:0] ii, input logic [31:0] st,
                     input logic [31:0] ca, input logic [31:0] epc_in);
    rec_t r;
    valid_i = v; pc_i = pc; in_delayslot_i = ds; excep_type_i = et;
    mem_addr_i = addr; int_i = ii; cp0_status_i = st; cp0_cause_i = ca; cp0_epc_i = epc_in;
    ints[e+1] = ii;
    if (v && (e + 1 >= next_ok) && model(pc, ds, et, addr, ints[e-1], st, ca, epc_in, r)) begin
      sb.push_back(r);
      for (int j = 1; j <= F; j++) begin
        exp_flush[e+j] = 1'b1;
        exp_newpc[e+j] = r.newpc;
      end
      next_ok = e + 1 + F + 2;
    end
    @(posedge clk);
    e++;
    #1;
  endtask

  task automatic idle(input int n, input logic [5:0] ii, input logic [31:0] st);
    for (int i = 0; i < n; i++) cyc(0, 32'h0, 0, 32'h0, 32'h0, ii, st, 32'h0, 32'h0);
  endtask

  always @(negedge clk) begin
    rec_t r;
    if (!rst && e >= 2) begin
      check("hw_ip", 32'(hw_ip_o), 32'(ints[e-1]));
      check("flush", 32'(flush_o), 32'(exp_flush[e]));
      check("stall", 32'(stall_o), 32'(exp_flush[e]));
      if (exp_flush[e]) check("new_pc", new_pc_o, exp_newpc[e]);
      if (excep_valid_o || eret_o) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_commit: got valid=%0b eret=%0b, expected none (cycle %0d)",
                   excep_valid_o, eret_o, e);
        end else begin
          r = sb.pop_front();
          check("eret", 32'(eret_o), 32'(r.eret));
          check("excep_valid", 32'(excep_valid_o), 32'(!r.eret));
          if (!r.eret) begin
            check("code", 32'(excep_code_o), 32'(r.code));
            check("epc", excep_epc_o, r.epc);
            check("bd", 32'(excep_bd_o), 32'(r.bd));
            check("epc_we", 32'(epc_we_o), 32'(r.epc_we));
            check("badvaddr_we", 32'(badvaddr_we_o), 32'(r.bav_we));
            if (r.bav_we) check("badvaddr", badvaddr_o, r.bav);
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] et;
    logic [5:0]  ii;
    for (int i = 0; i < N; i++) ints[i] = 6'd0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_flush", 32'(flush_o), 32'd0);
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_valid", 32'(excep_valid_o), 32'd0);
    check("rst_eret", 32'(eret_o), 32'd0);
    check("rst_hw_ip", 32'(hw_ip_o), 32'd0);
    check("rst_new_pc", new_pc_o, 32'd0);
    rst = 1'b0;
    e   = 2;
    next_ok = 3;

    // Syscall, not in a delay slot.
    cyc(1, 32'h8000_1000, 0, 32'h1 << 27, 32'h0, 6'h0, 32'h0000_FF01, 32'h0, 32'h0);
    idle(5, 6'h0, 32'h0000_FF01);
    // RI and Ov together in a delay slot: RI wins.
    cyc(1, 32'h8000_2004, 1, (32'h1 << 30) | (32'h1 << 29), 32'h0, 6'h0, 32'h0000_FF01, 32'h0, 32'h0);
    idle(5, 6'h0, 32'h0000_FF01);
    // Data AdES.
    cyc(1, 32'h8000_0010, 0, 32'h1 << 25, 32'h8000_0003, 6'h0, 32'h0000_FF01, 32'h0, 32'h0);
    idle(5, 6'h0, 32'h0000_FF01);
    // Interrupt line 0, unmasked.
    idle(3, 6'h01, 32'h0000_0401);
    cyc(1, 32'h8000_3000, 0, 32'h0, 32'h0, 6'h01, 32'h0000_0401, 32'h0, 32'h0);
    idle(5, 6'h01, 32'h0000_0401);
    // Same interrupt with EXL set: nothing taken.
    cyc(1, 32'h8000_3000, 0, 32'h0, 32'h0, 6'h01, 32'h0000_0403, 32'h0, 32'h0);
    idle(5, 6'h00, 32'h0000_0403);
    // ERET.
    cyc(1, 32'h8000_3100, 0, 32'h1, 32'h0, 6'h0, 32'h0000_FF03, 32'h0, 32'h8000_4000);
    idle(5, 6'h0, 32'h0000_FF03);
    // Nested syscall under EXL, a second syscall during FLUSH, then reset mid-FLUSH.
    cyc(1, 32'h8000_5000, 0, 32'h1 << 27, 32'h0, 6'h0, 32'h0000_FF03, 32'h0, 32'h0);
    cyc(1, 32'h8000_5004, 0, 32'h1 << 27, 32'h0, 6'h0, 32'h0000_FF03, 32'h0, 32'h0);
    valid_i = 1'b0;
    for (int j = e; j <= e + F + 3; j++) exp_flush[j] = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("midrst_flush", 32'(flush_o), 32'd0);
    check("midrst_stall", 32'(stall_o), 32'd0);
    #2 rst = 1'b0;
    next_ok = e + 1;
    idle(3, 6'h0, 32'h0000_FF01);

    // Randomized traffic.
    ii = 6'h0;
    for (int i = 0; i < 1500; i++) begin
      et = 32'h0;
      if ($urandom_range(3) == 0) et = $urandom & 32'h01FF_FFFE;
      for (int k = 0; k < 7; k++) if ($urandom_range(11) == 0) et[pri_bit[k]] = 1'b1;
      if ($urandom_range(7) == 0) et[0] = 1'b1;
      if ($urandom_range(15) == 0) ii = 6'($urandom);
      cyc($urandom_range(9) < 6, $urandom & 32'hFFFF_FFFC, 1'($urandom), et, $urandom, ii,
          st_pool[$urandom_range(5)], $urandom & 32'h0000_0300, $urandom & 32'hFFFF_FFFC);
    end
    idle(6, ii, 32'h0000_0000);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
